tff_toggle_sched: RTL
=====================

Name: tff_toggle_sched

Overview:
Round-robin scheduler that shares one bank of T flip-flops between several requesters. Each granted requester supplies a toggle mask and a pulse count. The block drives the bank's t inputs for exactly that many cycles, waits one settle cycle, then returns the resulting bank state with a one-cycle done pulse. It sits between the test/sequencing agents and the TFF bank (bank: q <= q ^ t on posedge clk).

Parameters:
NREQ, 4, number of requesters (>=2)
WIDTH, 8, TFF bank width
CNT_W, 4, width of toggle-count field (max count 2**CNT_W-1)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
req  input  NREQ  level request per requester
req_mask  input  NREQ*WIDTH  per-requester toggle mask, requester i at [i*WIDTH +: WIDTH]
req_cnt  input  NREQ*CNT_W  per-requester toggle count, requester i at [i*CNT_W +: CNT_W]
q_in  input  WIDTH  current TFF bank state
t  output  WIDTH  toggle enables to bank
gnt  output  NREQ  one-hot, one-cycle grant pulse
done  output  NREQ  one-hot, one-cycle completion pulse to granted requester
q_snap  output  WIDTH  bank state captured at completion, valid while done is high, held until the next capture
busy  output  1  high in every state except IDLE
err  output  1  mismatch flag, valid with done (see Optional Feature)

Behaviour:
- Reset (sync, rst=1 at a posedge): state=IDLE, t=0, gnt=0, done=0, busy=0, q_snap=0, err=0, rr pointer=NREQ-1 (requester 0 wins first).
- rst mid-operation aborts the transaction immediately. No done is issued. t is 0 from the next cycle.
- States: IDLE, RUN, SETTLE, DONE. All outputs are registered.
- IDLE: at a posedge with req!=0, the winner is the first set bit searching from ptr+1 upward, wrapping mod NREQ.
  - On that edge: latch mask_r=req_mask[win], cnt_r=req_cnt[win], q_start=q_in; set ptr=win; gnt[win]=1 for the following cycle only; busy=1.
  - Next state is RUN if cnt!=0, otherwise SETTLE.
- RUN: t=mask_r for exactly cnt_r consecutive cycles; the first t cycle is the same cycle gnt is high. Internal remaining counter decrements each RUN cycle. When remaining==1, next state is SETTLE.
- SETTLE: t=0 for one cycle, so the bank has applied its last toggle. At the end of SETTLE, q_snap<=q_in and the err result is computed.
- DONE: done[ptr]=1 for one cycle, q_snap valid; next state is IDLE with busy=0.
- Latency for count N>0: gnt at cycle 1, t during cycles 1..N, SETTLE at N+1, done at N+2. For count 0: done at cycle 2, t never asserted.
- Request rules:
  - A requester must deassert req no later than its done cycle, otherwise it may be re-granted.
  - A request arriving while busy waits; it is not lost if held.
  - mask and cnt are sampled only at grant; later changes are ignored.
- Simultaneous requests: resolved strictly by rotating priority. A requester that was just served has lowest priority next.
- Count arithmetic: unsigned, no wrap. Maximum count 2**CNT_W-1 yields that many t cycles.

Optional Feature:
Macro TFF_SCHED_CHECK_EN.
- Defined: at the end of SETTLE, expected = q_start ^ (cnt_r[0] ? mask_r : 0). err=1 during the DONE cycle if q_in != expected, else 0.
- Not defined: err is tied to 0, and the q_start register and comparator are not instantiated.

Test Plan:
- Reset: hold rst 2 cycles with req=4'b1111 -> t=0, gnt=0, done=0, busy=0, q_snap=0; first grant after release goes to requester 0.
- Single toggle: bank q=8'h00, req[1]=1, mask=8'hA5, cnt=3 -> gnt[1] at cycle 1; t=8'hA5 for cycles 1-3; done[1] at cycle 5; q_snap=8'hA5; err=0.
- Zero count: req[2], mask=8'hFF, cnt=0 -> t never nonzero; done[2] at cycle 2; q_snap equals the starting q.
- Round-robin: req=4'b1111 held, each requester dropping its req on its own done -> grant order 0,1,2,3; afterwards req=4'b1001 -> 0 then 3.
- Mid-operation reset: cnt=15, assert rst during the 5th RUN cycle -> t=0 the next cycle, no done, busy=0, ptr=3.
- Check (TFF_SCHED_CHECK_EN): force the bank model to ignore bit 0 -> err=1 with done for mask=8'h01, cnt=1; without the macro, err stays 0.

Source files
------------

// File: rtl/tff_toggle_sched.sv
// Round-robin scheduler sharing one T flip-flop bank between NREQ requesters.
// Optional end-of-transaction bank check enabled by macro TFF_SCHED_CHECK_EN.
//
// state  | meaning
// IDLE   | waiting for a request; arbitrates and latches mask/count on grant
// RUN    | drives t = mask_r, one cycle per remaining count
// SETTLE | t = 0 so the bank applies its final toggle; snapshot taken at end
// DONE   | one-cycle done pulse to the served requester, q_snap valid
module tff_toggle_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_mask,
  input  logic [NREQ*CNT_W-1:0]  req_cnt,
  input  logic [WIDTH-1:0]       q_in,
  output logic [WIDTH-1:0]       t,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic [WIDTH-1:0]       q_snap,
  output logic                   busy,
  output logic                   err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, DONE} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic             found;
  logic [WIDTH-1:0] win_mask;
  logic [CNT_W-1:0] win_cnt;
  logic [WIDTH-1:0] mask_r;
  logic [CNT_W-1:0] rem;

  // First set request searching upward from ptr+1, wrapping; the requester
  // at ptr (last served) is considered last.
  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    win      = ptr;
    win_mask = '0;
    win_cnt  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        win      = PW'(j);
        win_mask = req_mask[j*WIDTH +: WIDTH];
        win_cnt  = req_cnt[j*CNT_W +: CNT_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      q_snap <= '0;
      ptr    <= PW'(NREQ - 1);
      mask_r <= '0;
      rem    <= '0;
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            ptr    <= win;
            mask_r <= win_mask;
            rem    <= win_cnt;
            gnt    <= NREQ'(1) << win;
            busy   <= 1'b1;
            if (win_cnt != '0) begin
              t     <= win_mask;
              state <= RUN;
            end else begin
              state <= SETTLE;
            end
          end
        end
        RUN: begin
          if (rem == CNT_W'(1)) begin
            t     <= '0;
            state <= SETTLE;
          end else begin
            rem <= rem - CNT_W'(1);
            t   <= mask_r;
          end
        end
        SETTLE: begin
          q_snap <= q_in;
          done   <= NREQ'(1) << ptr;
          state  <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TFF_SCHED_CHECK_EN
  logic [WIDTH-1:0] q_start;
  logic             cnt_odd;
  logic             err_r;

  // An odd number of toggles leaves the masked bits inverted, even leaves them unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_start <= '0;
      cnt_odd <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        q_start <= q_in;
        cnt_odd <= win_cnt[0];
      end
      if (state == SETTLE)
        err_r <= (q_in != (q_start ^ (cnt_odd ? mask_r : '0)));
      else
        err_r <= 1'b0;
    end
  end

  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule
